// File: rtl/stsystem_pkg.sv
// Shared definitions for the serial transmission system (transmitter and receiver).
package stsystem_pkg;

  localparam int unsigned FRAME_LEN  = 11;
  localparam int unsigned DATA_W     = 8;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/stsystem_rx_if.sv
// Parallel output port of the receiver: byte, status flags and valid/ready handshake.
interface stsystem_rx_if;
  import stsystem_pkg::*;

  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              dready;
  logic              perr;
  logic              ferr;
  logic              ovr;

  modport master (
    output dout,
    output dvalid,
    input  dready,
    output perr,
    output ferr,
    output ovr
  );

  modport slave (
    input  dout,
    input  dvalid,
    output dready,
    input  perr,
    input  ferr,
    input  ovr
  );

endinterface

// File: rtl/stsystem_parity.sv
// Combinational parity generator; also used by the transmitter for its parity bit.
module stsystem_parity
  import stsystem_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic [DATA_W-1:0] d,
  output logic              p
);

  // Odd parity: d plus p carries an odd number of ones.
  assign p = (^d) ^ ODD_PARITY;

endmodule

// File: rtl/stsystem_rx.sv
// Serial frame receiver: {start, d[7:0] MSB-first, parity, stop} to a registered byte port.
module stsystem_rx
  import stsystem_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic                rxclk,
  input  logic                rst_n,
  input  logic                RX,
  stsystem_rx_if.master       bus
);

  rx_state_e         state, state_next;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] sreg;
  logic              par_bit;
  logic              par_exp;

  logic              cnt_clr, shift_en, par_cap, commit;

  logic [DATA_W-1:0] dout;
  logic              dvalid, perr, ferr, ovr;
  logic              handshake, accept;

  stsystem_parity #(
    .ODD_PARITY(ODD_PARITY)
  ) u_parity (
    .d(sreg),
    .p(par_exp)
  );

  // State register.
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: one sample per state except DATA, which takes eight.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (RX == START_BIT) state_next = DATA;
      DATA:    if (cnt == 3'd7) state_next = PARITY;
      PARITY:  state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes decoded from the current state.
  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    par_cap  = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE:    cnt_clr  = (RX == START_BIT);
      DATA:    shift_en = 1'b1;
      PARITY:  par_cap  = 1'b1;
      STOP:    commit   = 1'b1;
      default: ;
    endcase
  end

  // Bit counter, data shift register and captured parity bit.
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sreg    <= '0;
      par_bit <= 1'b0;
    end else begin
      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + 3'd1;
      if (shift_en) sreg <= {sreg[DATA_W-2:0], RX};
      if (par_cap)  par_bit <= RX;
    end
  end

  assign handshake = dvalid & bus.dready;
  // A commit lands only if the slot is empty or being emptied this very cycle.
  assign accept    = commit & (~dvalid | handshake);

  // Output register, handshake and sticky overrun flag.
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      dvalid <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
    end else if (accept) begin
      dout   <= sreg;
      dvalid <= 1'b1;
      perr   <= (par_bit != par_exp);
      ferr   <= (RX != STOP_BIT);
    end else if (commit) begin
      ovr    <= 1'b1;
    end else if (handshake) begin
      dvalid <= 1'b0;
    end
  end

  assign bus.dout   = dout;
  assign bus.dvalid = dvalid;
  assign bus.perr   = perr;
  assign bus.ferr   = ferr;
  assign bus.ovr    = ovr;

endmodule

// File: tb/tb_stsystem_rx.sv
// Directed bench for stsystem_rx: one odd-parity and one even-parity instance on a shared line.
module tb_stsystem_rx;
  import stsystem_pkg::*;

  logic rxclk = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b0;
  logic dready = 1'b0;

  int tests = 0;
  int fails = 0;

  stsystem_rx_if o_if ();
  stsystem_rx_if e_if ();

  assign o_if.dready = dready;
  assign e_if.dready = dready;

  stsystem_rx #(.ODD_PARITY(1'b1)) u_dut (
    .rxclk(rxclk),
    .rst_n(rst_n),
    .RX   (rx),
    .bus  (o_if.master)
  );

  stsystem_rx #(.ODD_PARITY(1'b0)) u_dut_even (
    .rxclk(rxclk),
    .rst_n(rst_n),
    .RX   (rx),
    .bus  (e_if.master)
  );

  always #5 rxclk = ~rxclk;

  task automatic do_reset();
    @(negedge rxclk);
    rst_n  = 1'b0;
    rx     = 1'b0;
    dready = 1'b0;
    repeat (2) @(negedge rxclk);
    rst_n = 1'b1;
  endtask

  // Drives the 11 line bits on falling edges; rdy_stop is driven alongside the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic rdy_stop);
    logic [10:0] bits;
    bits = {1'b1, d, par, stop};
    for (int i = 10; i >= 0; i--) begin
      @(negedge rxclk);
      rx = bits[i];
      if (i == 0) dready = rdy_stop;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge rxclk);
      rx     = 1'b0;
      dready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge rxclk);
    tests++;
    if ({o_if.dout, o_if.dvalid, o_if.perr, o_if.ferr, o_if.ovr} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: got dout=%h dvalid=%b perr=%b ferr=%b ovr=%b, want all 0",
               o_if.dout, o_if.dvalid, o_if.perr, o_if.ferr, o_if.ovr);
    end
    // Idle line (0) must not start a frame.
    idle_cycles(12);
    tests++;
    if (o_if.dvalid !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_frame: got dvalid=%b, want 0", o_if.dvalid);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    // Still inside cycle k+10: nothing committed yet.
    tests++;
    if (o_if.dvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_early: got dvalid=%b before stop edge, want 0", o_if.dvalid);
    end
    idle_cycles(1);
    tests++;
    if ({o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL single_frame: got dvalid=%b dout=%h perr=%b ferr=%b, want 1 a5 0 0",
               o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr);
    end
    idle_cycles(3);
    tests++;
    if (o_if.dvalid !== 1'b1) begin
      fails++;
      $display("FAIL single_hold: got dvalid=%b with dready low, want 1", o_if.dvalid);
    end
    @(negedge rxclk);
    dready = 1'b1;
    @(negedge rxclk);
    dready = 1'b0;
    tests++;
    if ({o_if.dvalid, o_if.dout} !== {1'b0, 8'hA5}) begin
      fails++;
      $display("FAIL single_consume: got dvalid=%b dout=%h, want 0 a5", o_if.dvalid, o_if.dout);
    end
  endtask

  task automatic test_parity_error();
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    tests++;
    if ({o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL parity_error: got dvalid=%b dout=%h perr=%b ferr=%b, want 1 a5 1 0",
               o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr);
    end
  endtask

  task automatic test_framing_error();
    do_reset();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    idle_cycles(1);
    tests++;
    if ({o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL framing_error: got dvalid=%b dout=%h perr=%b ferr=%b, want 1 a5 0 1",
               o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr);
    end
    tests++;
    if (u_dut.state !== IDLE) begin
      fails++;
      $display("FAIL framing_idle: got state=%0d, want IDLE", u_dut.state);
    end
    @(negedge rxclk);
    dready = 1'b1;
    @(negedge rxclk);
    dready = 1'b0;
    // Follow-on all-zero frame: odd parity bit is 1.
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    tests++;
    if ({o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL framing_followon: got dvalid=%b dout=%h perr=%b ferr=%b, want 1 00 0 0",
               o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    tests++;
    if ({o_if.dvalid, o_if.dout, o_if.ovr} !== {1'b1, 8'h3C, 1'b1}) begin
      fails++;
      $display("FAIL overrun: got dvalid=%b dout=%h ovr=%b, want 1 3c 1",
               o_if.dvalid, o_if.dout, o_if.ovr);
    end
    idle_cycles(5);
    tests++;
    if (o_if.ovr !== 1'b1) begin
      fails++;
      $display("FAIL ovr_sticky: got ovr=%b, want 1", o_if.ovr);
    end

    do_reset();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    idle_cycles(1);
    tests++;
    if ({o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr, o_if.ovr} !==
        {1'b1, 8'hC3, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL b2b_accept: got dvalid=%b dout=%h perr=%b ferr=%b ovr=%b, want 1 c3 0 0 0",
               o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr, o_if.ovr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    // Start plus five data bits of 0xFF, then reset.
    bits = {1'b1, 8'hFF, 1'b1, 1'b0};
    for (int i = 10; i >= 5; i--) begin
      @(negedge rxclk);
      rx = bits[i];
    end
    @(negedge rxclk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({o_if.dout, o_if.dvalid, o_if.perr, o_if.ferr, o_if.ovr} !== 12'h000) begin
      fails++;
      $display("FAIL mid_reset: got dout=%h dvalid=%b perr=%b ferr=%b ovr=%b, want all 0",
               o_if.dout, o_if.dvalid, o_if.perr, o_if.ferr, o_if.ovr);
    end
    rx = 1'b0;
    @(negedge rxclk);
    rst_n = 1'b1;
    idle_cycles(2);
    tests++;
    if (o_if.dvalid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_nocommit: got dvalid=%b, want 0", o_if.dvalid);
    end
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    tests++;
    if ({o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr, o_if.ovr} !==
        {1'b1, 8'h81, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL after_reset_frame: got dvalid=%b dout=%h perr=%b ferr=%b ovr=%b, want 1 81 0 0 0",
               o_if.dvalid, o_if.dout, o_if.perr, o_if.ferr, o_if.ovr);
    end
  endtask

  task automatic test_even_parity();
    do_reset();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    tests++;
    if ({e_if.dvalid, e_if.dout, e_if.perr} !== {1'b1, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL even_ok: got dvalid=%b dout=%h perr=%b, want 1 ff 0",
               e_if.dvalid, e_if.dout, e_if.perr);
    end
    // Same frame on the odd-parity instance is a parity error.
    tests++;
    if (o_if.perr !== 1'b1) begin
      fails++;
      $display("FAIL odd_on_ff: got perr=%b, want 1", o_if.perr);
    end
    @(negedge rxclk);
    dready = 1'b1;
    @(negedge rxclk);
    dready = 1'b0;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    tests++;
    if ({e_if.dvalid, e_if.dout, e_if.perr} !== {1'b1, 8'hFF, 1'b1}) begin
      fails++;
      $display("FAIL even_bad: got dvalid=%b dout=%h perr=%b, want 1 ff 1",
               e_if.dvalid, e_if.dout, e_if.perr);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_error();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_even_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
